// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - shared types, encodings and level decode for the irrigation zone controller
package irrigation_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REFILL   = 2'b01,
        ST_IRRIGATE = 2'b10,
        ST_FAULT    = 2'b11
    } state_e;

    localparam logic MODE_DRIP      = 1'b0;
    localparam logic MODE_SPRINKLER = 1'b1;

    // Widest sensor bus the decoder supports; narrower buses are zero-extended.
    localparam int MAX_LEVEL_BITS = 32;
    localparam int LVL_W          = 6;

    typedef struct packed {
        logic [LVL_W-1:0] level;
        logic             valid;
    } level_dec_t;

    // A set bit is legal only if every bit below it is also set, i.e. the
    // count of set bits seen so far equals its index.
    function automatic level_dec_t thermo_decode(input logic [MAX_LEVEL_BITS-1:0] code,
                                                 input int width);
        level_dec_t res;
        res.level = '0;
        res.valid = 1'b1;
        for (int i = 0; i < MAX_LEVEL_BITS; i++) begin
            if (code[i]) begin
                if (i >= width || int'(res.level) != i) begin
                    res.valid = 1'b0;
                end
                res.level = res.level + 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/irrigation_zone_controller_if.sv
// rtl/irrigation_zone_controller_if.sv - sensor/request inputs and valve/pump outputs of the zone controller
interface irrigation_zone_controller_if #(
    parameter int N_ZONES    = 4,
    parameter int LEVEL_BITS = 4
);
    localparam int ZW = $clog2(N_ZONES);

    logic [LEVEL_BITS-1:0] water_tank_level;
    logic [N_ZONES-1:0]    zone_req;
    logic [N_ZONES-1:0]    zone_mode;
    logic [1:0]            state;
    logic [N_ZONES-1:0]    valve_en;
    logic [ZW-1:0]         active_zone;
    logic                  pump_fill;
    logic                  transition;
    logic                  fault;

    // Sensor/switch side drives levels and requests, observes drivers.
    modport master (
        output water_tank_level, zone_req, zone_mode,
        input  state, valve_en, active_zone, pump_fill, transition, fault
    );

    // Controller side.
    modport slave (
        input  water_tank_level, zone_req, zone_mode,
        output state, valve_en, active_zone, pump_fill, transition, fault
    );
endinterface

// File: rtl/irrigation_zone_controller_zone_rr_arbiter.sv
// rtl/irrigation_zone_controller_zone_rr_arbiter.sv - combinational round-robin zone search
module zone_rr_arbiter #(
    parameter int N_ZONES = 4,
    parameter int PTR_W   = $clog2(N_ZONES)
) (
    input  logic [N_ZONES-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   grant,
    output logic               grant_valid
);

    // Walk the search order backwards so the last hit written is the first
    // eligible zone after ptr.
    always_comb begin
        int idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = N_ZONES; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_ZONES;
            if (eligible[PTR_W'(idx)]) begin
                grant       = PTR_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irrigation_zone_controller.sv
// rtl/irrigation_zone_controller.sv - multi-zone irrigation sequencer with shared tank refill and fault handling
module irrigation_zone_controller
    import irrigation_pkg::*;
#(
    parameter int N_ZONES         = 4,
    parameter int LEVEL_BITS      = 4,
    parameter int LOW_LEVEL       = 1,
    parameter int SPRINKLER_LEVEL = 3,
    parameter int HIGH_LEVEL      = 4,
    parameter int DURATION        = 16,
    parameter int REFILL_TIMEOUT  = 64
) (
    input logic                       clk,
    input logic                       initialize,
    irrigation_zone_controller_if.slave bus
);

    localparam int ZW = $clog2(N_ZONES);
    localparam int TW = $clog2(DURATION + 1);
    localparam int RW = $clog2(REFILL_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [RW-1:0]      refill_q, refill_d;
    logic [ZW-1:0]      ptr_q, ptr_d;
    logic [ZW-1:0]      active_zone_q, active_zone_d;
    logic [N_ZONES-1:0] valve_en_q, valve_en_d;
    logic               pump_fill_q, pump_fill_d;
    logic               transition_q, transition_d;
    logic               fault_q, fault_d;

    level_dec_t         dec;
    int                 lvl;
    logic [N_ZONES-1:0] eligible;
    logic               active_eligible;
    logic [ZW-1:0]      grant;
    logic               grant_valid;

    // Decode the thermometer bus and qualify each zone against its mode threshold.
    always_comb begin
        dec = thermo_decode(MAX_LEVEL_BITS'(bus.water_tank_level), LEVEL_BITS);
        lvl = int'(dec.level);
        eligible = '0;
        for (int z = 0; z < N_ZONES; z++) begin
            eligible[z] = bus.zone_req[z] &&
                          (lvl >= ((bus.zone_mode[z] == MODE_SPRINKLER) ? SPRINKLER_LEVEL : LOW_LEVEL));
        end
        active_eligible = eligible[active_zone_q];
    end

    zone_rr_arbiter #(
        .N_ZONES (N_ZONES),
        .PTR_W   (ZW)
    ) u_arb (
        .eligible    (eligible),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // State and registered outputs; initialize clears everything at the same edge.
    always_ff @(posedge clk) begin
        if (initialize) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            refill_q      <= '0;
            ptr_q         <= ZW'(N_ZONES - 1);
            active_zone_q <= '0;
            valve_en_q    <= '0;
            pump_fill_q   <= 1'b0;
            transition_q  <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            refill_q      <= refill_d;
            ptr_q         <= ptr_d;
            active_zone_q <= active_zone_d;
            valve_en_q    <= valve_en_d;
            pump_fill_q   <= pump_fill_d;
            transition_q  <= transition_d;
            fault_q       <= fault_d;
        end
    end

    // Next-state decision; an invalid sensor code trumps every other condition.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        refill_d      = refill_q;
        ptr_d         = ptr_q;
        active_zone_d = active_zone_q;
        if (!dec.valid && state_q != ST_FAULT) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lvl < LOW_LEVEL) begin
                        state_d  = ST_REFILL;
                        refill_d = '0;
                    end else if (grant_valid) begin
                        state_d       = ST_IRRIGATE;
                        active_zone_d = grant;
                        timer_d       = TW'(DURATION - 1);
                    end
                end
                ST_IRRIGATE: begin
                    if (timer_q == '0 || !active_eligible) begin
                        ptr_d    = active_zone_q;
                        refill_d = '0;
                        state_d  = (lvl < LOW_LEVEL) ? ST_REFILL : ST_IDLE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_REFILL: begin
                    refill_d = refill_q + 1'b1;
                    if (lvl >= HIGH_LEVEL) begin
                        state_d = ST_IDLE;
                    end else if (refill_q == RW'(REFILL_TIMEOUT - 1)) begin
                        state_d = ST_FAULT;
                    end
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end
    end

    // Output values for the state being entered, registered next edge.
    always_comb begin
        valve_en_d   = '0;
        pump_fill_d  = 1'b0;
        fault_d      = 1'b0;
        transition_d = (state_d != state_q);
        case (state_d)
            ST_IRRIGATE: valve_en_d  = {{(N_ZONES-1){1'b0}}, 1'b1} << active_zone_d;
            ST_REFILL:   pump_fill_d = 1'b1;
            ST_FAULT:    fault_d     = 1'b1;
            default:     valve_en_d  = '0;
        endcase
    end

    assign bus.state       = state_q;
    assign bus.valve_en    = valve_en_q;
    assign bus.active_zone = active_zone_q;
    assign bus.pump_fill   = pump_fill_q;
    assign bus.transition  = transition_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_irrigation_zone_controller.sv
// tb/tb_irrigation_zone_controller.sv - table-driven and sequence checks of irrigation_zone_controller
module tb_irrigation_zone_controller;

    logic clk = 1'b0;
    logic initialize;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    irrigation_zone_controller_if #(.N_ZONES(4), .LEVEL_BITS(4)) bus ();

    irrigation_zone_controller dut (
        .clk        (clk),
        .initialize (initialize),
        .bus        (bus)
    );

    typedef struct {
        logic       rst;
        logic [3:0] lvl;
        logic [3:0] req;
        logic [3:0] mode;
        logic [1:0] st;
        logic [3:0] valve;
        logic [1:0] zone;
        logic       pump;
        logic       trans;
        logic       flt;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic rst, input logic [3:0] lvl, input logic [3:0] req, input logic [3:0] mode);
        initialize           = rst;
        bus.water_tank_level = lvl;
        bus.zone_req         = req;
        bus.zone_mode        = mode;
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0111, 4'b0000, 4'b0000);
        step();
        initialize = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [3:0] valve,
                             input logic [1:0] zone, input logic pump, input logic trans, input logic flt);
        check({tag, "_state"}, 32'(bus.state), 32'(st));
        check({tag, "_valve"}, 32'(bus.valve_en), 32'(valve));
        check({tag, "_zone"},  32'(bus.active_zone), 32'(zone));
        check({tag, "_pump"},  32'(bus.pump_fill), 32'(pump));
        check({tag, "_trans"}, 32'(bus.transition), 32'(trans));
        check({tag, "_fault"}, 32'(bus.fault), 32'(flt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        //            rst  lvl      req      mode     st     valve    zone   p  t  f
        tbl[0]  = '{1'b0, 4'b0011, 4'b0110, 4'b0100, 2'b10, 4'b0010, 2'd1, 0, 1, 0};
        tbl[1]  = '{1'b0, 4'b0011, 4'b0110, 4'b0100, 2'b10, 4'b0010, 2'd1, 0, 0, 0};
        tbl[2]  = '{1'b0, 4'b0111, 4'b0100, 4'b0100, 2'b00, 4'b0000, 2'd1, 0, 1, 0};
        tbl[3]  = '{1'b0, 4'b0111, 4'b0110, 4'b0100, 2'b10, 4'b0100, 2'd2, 0, 1, 0};
        tbl[4]  = '{1'b0, 4'b0111, 4'b0010, 4'b0100, 2'b00, 4'b0000, 2'd2, 0, 1, 0};
        tbl[5]  = '{1'b0, 4'b0111, 4'b0110, 4'b0100, 2'b10, 4'b0010, 2'd1, 0, 1, 0};
        tbl[6]  = '{1'b0, 4'b0011, 4'b0110, 4'b0100, 2'b10, 4'b0010, 2'd1, 0, 0, 0};
        tbl[7]  = '{1'b0, 4'b0001, 4'b0010, 4'b0100, 2'b10, 4'b0010, 2'd1, 0, 0, 0};
        tbl[8]  = '{1'b0, 4'b0000, 4'b0010, 4'b0100, 2'b01, 4'b0000, 2'd1, 1, 1, 0};
        tbl[9]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100, 2'b00, 4'b0000, 2'd1, 0, 1, 0};
        tbl[10] = '{1'b0, 4'b0111, 4'b0000, 4'b0100, 2'b00, 4'b0000, 2'd1, 0, 0, 0};
        tbl[11] = '{1'b0, 4'b1000, 4'b0000, 4'b0100, 2'b11, 4'b0000, 2'd1, 0, 1, 1};
        tbl[12] = '{1'b0, 4'b0111, 4'b0001, 4'b0100, 2'b11, 4'b0000, 2'd1, 0, 0, 1};
        tbl[13] = '{1'b1, 4'b0111, 4'b0110, 4'b0100, 2'b00, 4'b0000, 2'd0, 0, 0, 0};
        tbl[14] = '{1'b0, 4'b0111, 4'b0110, 4'b0000, 2'b10, 4'b0010, 2'd1, 0, 1, 0};
        tbl[15] = '{1'b0, 4'b0101, 4'b0110, 4'b0000, 2'b11, 4'b0000, 2'd1, 0, 1, 1};
        tbl[16] = '{1'b1, 4'b0111, 4'b0000, 4'b0000, 2'b00, 4'b0000, 2'd0, 0, 0, 0};

        drive(1'b1, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        step();
        step();
        check_all("reset", 2'b00, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        initialize = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].lvl, tbl[i].req, tbl[i].mode);
            step();
            check_all($sformatf("row%0d", i), tbl[i].st, tbl[i].valve, tbl[i].zone,
                      tbl[i].pump, tbl[i].trans, tbl[i].flt);
        end

        // Full watering window on zone 0.
        do_reset();
        drive(1'b0, 4'b0111, 4'b0001, 4'b0000);
        step();
        check("win_enter_state", 32'(bus.state), 32'(2'b10));
        check("win_enter_trans", 32'(bus.transition), 32'd1);
        n = 0;
        while (bus.valve_en == 4'b0001 && n < 40) begin
            n++;
            step();
        end
        check("win_len", 32'(n), 32'd16);
        check("win_end_state", 32'(bus.state), 32'(2'b00));
        check("win_end_trans", 32'(bus.transition), 32'd1);

        // Refill that completes after 10 cycles.
        do_reset();
        drive(1'b0, 4'b0000, 4'b1111, 4'b0000);
        step();
        check_all("refill_enter", 2'b01, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step();
        check("refill_mid_pump", 32'(bus.pump_fill), 32'd1);
        check("refill_mid_trans", 32'(bus.transition), 32'd0);
        bus.water_tank_level = 4'b1111;
        step();
        check_all("refill_done", 2'b00, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);

        // Refill watchdog with the level stuck at one sensor.
        do_reset();
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
        step();
        bus.water_tank_level = 4'b0001;
        n = 0;
        while (bus.pump_fill == 1'b1 && n < 100) begin
            n++;
            step();
        end
        check("wdog_pump_cycles", 32'(n), 32'd64);
        check_all("wdog_fault", 2'b11, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
        bus.water_tank_level = 4'b1111;
        bus.zone_req = 4'b1111;
        for (int i = 0; i < 5; i++) step();
        check_all("wdog_hold", 2'b11, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
        initialize = 1'b1;
        step();
        check_all("wdog_reset", 2'b00, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        initialize = 1'b0;

        // Request dropped mid-window, then reset while refilling.
        do_reset();
        drive(1'b0, 4'b0111, 4'b0001, 4'b0000);
        step();
        for (int i = 0; i < 4; i++) step();
        check("drop_before_valve", 32'(bus.valve_en), 32'(4'b0001));
        bus.zone_req = 4'b0000;
        step();
        check_all("drop_after", 2'b00, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        bus.water_tank_level = 4'b0000;
        step();
        step();
        check("rst_refill_pump_before", 32'(bus.pump_fill), 32'd1);
        initialize = 1'b1;
        step();
        check_all("rst_refill_after", 2'b00, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        initialize = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
